// File: rtl/branch_pkg.sv
// Shared definitions for the EX-stage branch/jump resolution controller.
// States, funct3 codes, instruction class encoding and the flush counter width.
package branch_pkg;

    // Controller states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RESOLVE = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

    // Conditional branch funct3 codes
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Control-transfer class of the latched instruction
    typedef enum logic [1:0] {
        CLS_BRANCH = 2'd0,
        CLS_JAL    = 2'd1,
        CLS_JALR   = 2'd2,
        CLS_NONE   = 2'd3
    } cls_e;

    // Flush countdown width; holds FLUSH_CYCLES in 1..7
    localparam int unsigned FCNT_W = 3;
    localparam logic [FCNT_W-1:0] FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

    // Comparator mode: only the unsigned branches clear it
    function automatic logic br_un_sel(cls_e cls, logic [2:0] f3);
        logic sel;
        sel = 1'b1;
        if (cls == CLS_BRANCH) begin
            if (f3 == F3_BLTU || f3 == F3_BGEU) begin
                sel = 1'b0;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/branch_decision.sv
// Combinational taken/illegal decision for one control-transfer instruction.
// Jumps are always taken; reserved branch funct3 codes are illegal, not taken.
module branch_decision
    import branch_pkg::*;
(
    input  cls_e       cls_i,
    input  logic [2:0] funct3_i,
    input  logic       less_i,
    input  logic       equal_i,
    output logic       taken_o,
    output logic       illegal_o
);

    logic br_taken;
    logic br_illegal;

    // Conditional branch outcome from funct3 and comparator flags
    always_comb begin
        br_taken   = 1'b0;
        br_illegal = 1'b0;
        case (funct3_i)
            F3_BEQ:  br_taken = equal_i;
            F3_BNE:  br_taken = ~equal_i;
            F3_BLT:  br_taken = less_i;
            F3_BGE:  br_taken = ~less_i;
            F3_BLTU: br_taken = less_i;
            F3_BGEU: br_taken = ~less_i;
            default: br_illegal = 1'b1;
        endcase
    end

    // Select outcome by instruction class
    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        unique case (cls_i)
            CLS_BRANCH: begin
                taken_o   = br_taken;
                illegal_o = br_illegal;
            end
            CLS_JAL:  taken_o = 1'b1;
            CLS_JALR: taken_o = 1'b1;
            CLS_NONE: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch/jump resolution controller with static not-taken prediction.
// Resolves one instruction at a time, redirects fetch and holds a front-end flush.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_is_branch,
    input  logic        i_is_jal,
    input  logic        i_is_jalr,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_rs1_data,
    input  logic        i_kill,
    output logic        o_br_un,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    output logic        o_resolved,
    output logic        o_taken,
    output logic        o_redirect,
    output logic [31:0] o_target,
    output logic        o_flush,
    output logic        o_illegal,
    output logic        o_misaligned,
    output logic [31:0] o_br_count,
    output logic [31:0] o_taken_count
);

    localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    cls_e              cls_q, cls_d;
    logic [2:0]        f3_q, f3_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       imm_q, imm_d;
    logic [31:0]       rs1_q, rs1_d;
    logic              br_un_q, br_un_d;
    logic              resolved_q, resolved_d;
    logic              taken_q, taken_d;
    logic              redirect_q, redirect_d;
    logic              illegal_q, illegal_d;
    logic              misal_q, misal_d;
    logic [31:0]       target_q, target_d;
    logic [31:0]       br_cnt_q, br_cnt_d;
    logic [31:0]       tk_cnt_q, tk_cnt_d;

    cls_e        cls_in;
    logic        dec_taken;
    logic        dec_illegal;
    logic [31:0] tgt_pc;
    logic [31:0] tgt_jalr;
    logic [31:0] tgt;

    // Encode the one-hot class inputs
    always_comb begin
        cls_in = CLS_NONE;
        case (1'b1)
            i_is_branch: cls_in = CLS_BRANCH;
            i_is_jal:    cls_in = CLS_JAL;
            i_is_jalr:   cls_in = CLS_JALR;
            default:     cls_in = CLS_NONE;
        endcase
    end

    branch_decision u_decision (
        .cls_i     (cls_q),
        .funct3_i  (f3_q),
        .less_i    (i_br_less),
        .equal_i   (i_br_equal),
        .taken_o   (dec_taken),
        .illegal_o (dec_illegal)
    );

    // Target adders; JALR clears bit 0 of the sum
    always_comb begin
        tgt_pc   = pc_q + imm_q;
        tgt_jalr = (rs1_q + imm_q) & ~32'h1;
        tgt      = (cls_q == CLS_JALR) ? tgt_jalr : tgt_pc;
    end

    // Next-state, pulse and counter logic
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        cls_d      = cls_q;
        f3_d       = f3_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        br_un_d    = br_un_q;
        resolved_d = 1'b0;
        taken_d    = 1'b0;
        redirect_d = 1'b0;
        illegal_d  = 1'b0;
        misal_d    = 1'b0;
        target_d   = target_q;
        br_cnt_d   = br_cnt_q;
        tk_cnt_d   = tk_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    cls_d   = cls_in;
                    f3_d    = i_funct3;
                    pc_d    = i_pc;
                    imm_d   = i_imm;
                    rs1_d   = i_rs1_data;
                    br_un_d = br_un_sel(cls_in, i_funct3);
                    state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                state_d = ST_IDLE;
                if (!i_kill) begin
                    resolved_d = 1'b1;
                    taken_d    = dec_taken;
                    illegal_d  = dec_illegal;
                    br_cnt_d   = br_cnt_q + 32'd1;
                    if (dec_taken) begin
                        tk_cnt_d = tk_cnt_q + 32'd1;
                        target_d = tgt;
                        if (tgt[1]) begin
                            misal_d = 1'b1;
                        end else begin
                            redirect_d = 1'b1;
                            fcnt_d     = FCNT_LOAD;
                            state_d    = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (fcnt_q <= FCNT_ONE) begin
                    fcnt_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    fcnt_d = fcnt_q - FCNT_ONE;
                end
            end
            default: begin
                fcnt_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            fcnt_q     <= '0;
            cls_q      <= CLS_NONE;
            f3_q       <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            br_un_q    <= 1'b1;
            resolved_q <= 1'b0;
            taken_q    <= 1'b0;
            redirect_q <= 1'b0;
            illegal_q  <= 1'b0;
            misal_q    <= 1'b0;
            target_q   <= '0;
            br_cnt_q   <= '0;
            tk_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            cls_q      <= cls_d;
            f3_q       <= f3_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            br_un_q    <= br_un_d;
            resolved_q <= resolved_d;
            taken_q    <= taken_d;
            redirect_q <= redirect_d;
            illegal_q  <= illegal_d;
            misal_q    <= misal_d;
            target_q   <= target_d;
            br_cnt_q   <= br_cnt_d;
            tk_cnt_q   <= tk_cnt_d;
        end
    end

    // Handshake and flush are pure functions of state
    always_comb begin
        o_ready = (state_q == ST_IDLE);
        o_flush = (state_q == ST_FLUSH);
    end

    assign o_br_un       = br_un_q;
    assign o_resolved    = resolved_q;
    assign o_taken       = taken_q;
    assign o_redirect    = redirect_q;
    assign o_target      = target_q;
    assign o_illegal     = illegal_q;
    assign o_misaligned  = misal_q;
    assign o_br_count    = br_cnt_q;
    assign o_taken_count = tk_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: vector table plus kill/reset/wrap sequences.
// Expected values are hand-computed and tracked in a small counter model.
module tb_branch_ctrl;

    localparam int FC = 2;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic        is_br, is_jal, is_jalr;
    logic [2:0]  f3;
    logic [31:0] pc, imm, rs1;
    logic        kill;
    logic        br_un;
    logic        less, equal;
    logic        resolved, taken, redirect, flush, illegal, misal;
    logic [31:0] target, br_cnt, tk_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_br = 0;
    logic [31:0] exp_tk = 0;

    branch_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_valid       (valid),
        .o_ready       (ready),
        .i_is_branch   (is_br),
        .i_is_jal      (is_jal),
        .i_is_jalr     (is_jalr),
        .i_funct3      (f3),
        .i_pc          (pc),
        .i_imm         (imm),
        .i_rs1_data    (rs1),
        .i_kill        (kill),
        .o_br_un       (br_un),
        .i_br_less     (less),
        .i_br_equal    (equal),
        .o_resolved    (resolved),
        .o_taken       (taken),
        .o_redirect    (redirect),
        .o_target      (target),
        .o_flush       (flush),
        .o_illegal     (illegal),
        .o_misaligned  (misal),
        .o_br_count    (br_cnt),
        .o_taken_count (tk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          cls;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        less;
        logic        equal;
        logic        e_brun;
        logic        e_taken;
        logic        e_ill;
        logic        e_mis;
        logic        e_redir;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({nm, "_ready_wait"}, 32'(ready), 32'd1);
    endtask

    task automatic offer(input int cls, input logic [2:0] fn,
                         input logic [31:0] p, input logic [31:0] im,
                         input logic [31:0] r);
        valid   = 1'b1;
        is_br   = (cls == 0);
        is_jal  = (cls == 1);
        is_jalr = (cls == 2);
        f3      = fn;
        pc      = p;
        imm     = im;
        rs1     = r;
    endtask

    task automatic idle_in();
        valid   = 1'b0;
        is_br   = 1'b0;
        is_jal  = 1'b0;
        is_jalr = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        wait_ready(v.name);
        offer(v.cls, v.f3, v.pc, v.imm, v.rs1);
        step();
        idle_in();
        less  = v.less;
        equal = v.equal;
        chk({v.name, "_ready_resolve"}, 32'(ready), 32'd0);
        chk({v.name, "_br_un"}, 32'(br_un), 32'(v.e_brun));
        step();
        exp_br = exp_br + 32'd1;
        if (v.e_taken) exp_tk = exp_tk + 32'd1;
        chk({v.name, "_resolved"}, 32'(resolved), 32'd1);
        chk({v.name, "_taken"}, 32'(taken), 32'(v.e_taken));
        chk({v.name, "_illegal"}, 32'(illegal), 32'(v.e_ill));
        chk({v.name, "_misal"}, 32'(misal), 32'(v.e_mis));
        chk({v.name, "_redirect"}, 32'(redirect), 32'(v.e_redir));
        chk({v.name, "_flush"}, 32'(flush), 32'(v.e_redir));
        if (v.e_taken) chk({v.name, "_target"}, target, v.e_tgt);
        chk({v.name, "_br_cnt"}, br_cnt, exp_br);
        chk({v.name, "_tk_cnt"}, tk_cnt, exp_tk);
        if (v.e_redir) begin
            chk({v.name, "_ready_t2"}, 32'(ready), 32'd0);
            for (int k = 1; k < FC; k++) begin
                step();
                chk({v.name, "_flush_hold"}, 32'(flush), 32'd1);
                chk({v.name, "_redir_pulse"}, 32'(redirect), 32'd0);
                chk({v.name, "_ready_flush"}, 32'(ready), 32'd0);
            end
            step();
            chk({v.name, "_flush_end"}, 32'(flush), 32'd0);
            chk({v.name, "_target_hold"}, target, v.e_tgt);
        end
        chk({v.name, "_ready_back"}, 32'(ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        kill  = 1'b0;
        less  = 1'b0;
        equal = 1'b0;
        f3    = '0;
        pc    = '0;
        imm   = '0;
        rs1   = '0;
        idle_in();

        //       name   cls f3      pc            imm           rs1           l  e  un tk il ms rd target
        vecs.push_back('{"beq_t",  0, 3'b000, 32'h100,      32'h20,       32'h0,    0, 1, 1, 1, 0, 0, 1, 32'h120});
        vecs.push_back('{"bltu_nt",0, 3'b110, 32'h104,      32'h20,       32'h0,    0, 0, 0, 0, 0, 0, 0, 32'h0});
        vecs.push_back('{"jalr_mis",2,3'b000, 32'h500,      32'h0,        32'h1003, 0, 0, 1, 1, 0, 1, 0, 32'h1002});
        vecs.push_back('{"jalr_ok",2, 3'b000, 32'h500,      32'h0,        32'h1001, 0, 0, 1, 1, 0, 0, 1, 32'h1000});
        vecs.push_back('{"ill_010",0, 3'b010, 32'h108,      32'h40,       32'h0,    1, 1, 1, 0, 1, 0, 0, 32'h0});
        vecs.push_back('{"ill_011",0, 3'b011, 32'h10C,      32'h40,       32'h0,    0, 0, 1, 0, 1, 0, 0, 32'h0});
        vecs.push_back('{"bne_t",  0, 3'b001, 32'h200,      32'hFFFFFFF8, 32'h0,    0, 0, 1, 1, 0, 0, 1, 32'h1F8});
        vecs.push_back('{"blt_t",  0, 3'b100, 32'h0,        32'h40,       32'h0,    1, 0, 1, 1, 0, 0, 1, 32'h40});
        vecs.push_back('{"bge_nt", 0, 3'b101, 32'h300,      32'h40,       32'h0,    1, 0, 1, 0, 0, 0, 0, 32'h0});
        vecs.push_back('{"bgeu_t", 0, 3'b111, 32'h3000,     32'h10,       32'h0,    0, 0, 0, 1, 0, 0, 1, 32'h3010});
        vecs.push_back('{"jal_wrap",1,3'b000, 32'hFFFFFFF0, 32'h20,       32'h0,    0, 0, 1, 1, 0, 0, 1, 32'h10});
        vecs.push_back('{"beq_nt", 0, 3'b000, 32'h400,      32'h8,        32'h0,    0, 0, 1, 0, 0, 0, 0, 32'h0});

        step();
        step();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_br_un", 32'(br_un), 32'd1);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_resolved", 32'(resolved), 32'd0);
        chk("rst_target", target, 32'd0);
        chk("rst_br_cnt", br_cnt, 32'd0);
        chk("rst_tk_cnt", tk_cnt, 32'd0);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Kill during RESOLVE of a BNE that would be taken
        wait_ready("kill");
        offer(0, 3'b001, 32'h600, 32'h20, 32'h0);
        step();
        idle_in();
        equal = 1'b0;
        kill  = 1'b1;
        step();
        kill = 1'b0;
        chk("kill_resolved", 32'(resolved), 32'd0);
        chk("kill_redirect", 32'(redirect), 32'd0);
        chk("kill_flush", 32'(flush), 32'd0);
        chk("kill_ready", 32'(ready), 32'd1);
        chk("kill_br_cnt", br_cnt, exp_br);
        chk("kill_tk_cnt", tk_cnt, exp_tk);

        // Kill while flushing is ignored
        offer(1, 3'b000, 32'h700, 32'h100, 32'h0);
        step();
        idle_in();
        step();
        exp_br = exp_br + 32'd1;
        exp_tk = exp_tk + 32'd1;
        kill = 1'b1;
        chk("kflush_target", target, 32'h800);
        step();
        chk("kflush_flush", 32'(flush), 32'd1);
        kill = 1'b0;
        step();
        chk("kflush_ready", 32'(ready), 32'd1);
        chk("kflush_br_cnt", br_cnt, exp_br);

        // Reset in the middle of a flush
        offer(0, 3'b000, 32'h900, 32'h20, 32'h0);
        step();
        idle_in();
        equal = 1'b1;
        step();
        chk("rflush_flush_on", 32'(flush), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_br = 0;
        exp_tk = 0;
        chk("rflush_flush_off", 32'(flush), 32'd0);
        chk("rflush_ready", 32'(ready), 32'd1);
        chk("rflush_br_cnt", br_cnt, 32'd0);
        chk("rflush_tk_cnt", tk_cnt, 32'd0);
        chk("rflush_target", target, 32'd0);
        chk("rflush_br_un", 32'(br_un), 32'd1);

        // Counter wrap from a forced all-ones preset
        dut.br_cnt_q = 32'hFFFFFFFF;
        dut.tk_cnt_q = 32'hFFFFFFFF;
        #1;
        offer(1, 3'b000, 32'h40, 32'h40, 32'h0);
        step();
        idle_in();
        step();
        chk("wrap_resolved", 32'(resolved), 32'd1);
        chk("wrap_br_cnt", br_cnt, 32'd0);
        chk("wrap_tk_cnt", tk_cnt, 32'd0);
        chk("wrap_target", target, 32'h80);
        repeat (FC) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch/jump resolution controller for the EX stage of the RISC-V core. It accepts one control-transfer instruction at a time and configures the branch comparator's signed/unsigned select from funct3. It samples the comparator's less/equal results, decides taken/not-taken under static not-taken prediction, and computes the target. On a taken result it issues a redirect and holds a fixed-length front-end flush.

## Interface
- FLUSH_CYCLES, 2: cycles o_flush stays high after a taken redirect (1..7).
- i_clk  in  1  core clock
- i_reset  in  1  synchronous, active-low reset
- i_valid  in  1  instruction offered by decode
- o_ready  out  1  controller can accept (high only in IDLE)
- i_is_branch / i_is_jal / i_is_jalr  in  1 each  instruction class, one-hot when i_valid
- i_funct3  in  3  branch funct3
- i_pc  in  32  instruction PC
- i_imm  in  32  sign-extended immediate
- i_rs1_data  in  32  rs1 value, used for the JALR target
- i_kill  in  1  older-instruction exception; aborts the in-flight resolve
- o_br_un  out  1  to comparator; 1 = signed compare, 0 = unsigned
- i_br_less, i_br_equal  in  1 each  comparator results
- o_resolved  out  1  one-cycle pulse: instruction resolved
- o_taken  out  1  valid with o_resolved
- o_redirect  out  1  one-cycle pulse: fetch must load o_target
- o_target  out  32  redirect PC, held until the next accept
- o_flush  out  1  squash IF/ID
- o_illegal  out  1  pulse with o_resolved: reserved funct3 (010/011)
- o_misaligned  out  1  pulse with o_resolved: taken target has bit 1 set
- o_br_count, o_taken_count  out  32 each  resolved-instruction and taken counters, wrapping

## Operation
- States: IDLE, RESOLVE, FLUSH.
- IDLE: o_ready = 1. On i_valid & o_ready, latch class, funct3, pc, imm, and rs1, then go to RESOLVE.
- RESOLVE: o_ready = 0. Datapath holds rs1/rs2 stable on the comparator. o_br_un comes from the latched funct3: 1 for 000/001/100/101, 0 for 110/111, and 1 for reserved codes and jumps.
- Decision at the end of RESOLVE:
  - BEQ: equal. BNE: !equal.
  - BLT/BLTU: less. BGE/BGEU: !less.
  - JAL/JALR: always taken.
  - Reserved funct3: not taken, o_illegal.
- Target:
  - Branch/JAL: pc + imm.
  - JALR: (rs1 + imm) & ~32'h1.
  - All sums are modulo 2^32.
- Taken and target[1] = 0: pulse o_redirect and o_resolved, load o_target, go to FLUSH.
- Taken and target[1] = 1: pulse o_resolved and o_misaligned with o_taken = 1. No redirect, no flush; return to IDLE.
- Not taken: pulse o_resolved with o_taken = 0; return to IDLE.
- FLUSH: o_flush = 1 for exactly FLUSH_CYCLES cycles, counted down by a 3-bit counter, then IDLE.
- Counters: o_br_count increments on every o_resolved. o_taken_count increments on o_resolved & o_taken, including misaligned. Both wrap 0xFFFFFFFF -> 0.
- i_kill in RESOLVE: next state IDLE; no o_resolved, no redirect, no count change. i_kill in FLUSH or IDLE is ignored; a flush already started always completes.
- Reset: state IDLE, flush counter 0. All outputs 0 except o_ready = 1 and o_br_un = 1. o_target = 0, counters = 0. Reset during RESOLVE or FLUSH abandons the operation with no pulses.

## Timing
- Accept at cycle T (edge ending T).
- RESOLVE occupies cycle T+1.
- o_resolved, o_redirect, and o_target are registered and valid in cycle T+2.
- o_flush is high in cycles T+2 .. T+1+FLUSH_CYCLES.
- o_ready returns:
  - at T+2 for not-taken, illegal, misaligned, or killed instructions;
  - at T+2+FLUSH_CYCLES for taken redirects.
- Back-to-back throughput: one instruction per 2 cycles when not taken.
- o_br_un is registered from the latched funct3 and stable for all of RESOLVE.
- o_ready is a pure function of state; there is no combinational path from i_valid to o_ready.

## Structure
- branch_pkg:
  - state enum;
  - funct3 localparams (F3_BEQ..F3_BGEU);
  - class encoding;
  - FLUSH counter width.
- Sub-module branch_decision: combinational; inputs class, funct3, less, equal; outputs taken and illegal. Reused for unit testing.
- Counters and target adders stay in branch_ctrl.

## Test plan
- BEQ, pc=0x100, imm=0x20, equal=1 -> T+2: o_redirect, o_target=0x120, o_flush for 2 cycles, o_ready at T+4, o_taken_count=1.
- BLTU with less=0 -> o_br_un=0 during RESOLVE, o_resolved & !o_taken, no flush, o_ready at T+2.
- JALR, rs1=0x1003, imm=0 -> o_target=0x1002, o_misaligned pulse, no redirect. JALR, rs1=0x1001 -> target 0x1000, redirect.
- funct3=010 branch -> o_illegal, not taken, o_br_count increments, o_taken_count unchanged.
- i_kill in RESOLVE of a taken BNE -> no pulses, counters unchanged, o_ready at T+2. Reset asserted mid-FLUSH -> o_flush low next cycle, counters 0.
- Counters preset to 0xFFFFFFFF by forced state, one taken JAL -> both wrap to 0.
